// File: rtl/fifo_consumer_pkg.sv
// fifo_consumer_pkg: state encodings shared by the FIFO-to-RAM write-back block.
// Revision 1.0
`default_nettype none

package fifo_consumer_pkg;

  typedef enum logic [0:0] {
    IDLE_B  = 1'b0,
    BURST_B = 1'b1
  } fifo_consumer_state_idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b01,
    BURST = 2'b10
  } fifo_consumer_state_t;

endpackage

`default_nettype wire

// File: rtl/single_port_ram_pkg.sv
// single_port_ram_pkg: control levels for the shared single-port RAM buffer (all active-low).
// Revision 1.0
`default_nettype none

package single_port_ram_pkg;

  localparam logic CS_EN    = 1'b0;
  localparam logic CS_DIS   = 1'b1;
  localparam logic OE_EN    = 1'b0;
  localparam logic OE_DIS   = 1'b1;
  localparam logic WREQ_EN  = 1'b0;
  localparam logic WREQ_DIS = 1'b1;

endpackage

`default_nettype wire

// File: rtl/fifo_consumer_if.sv
// sync_fifo_consumer_intf: read side of a synchronous FIFO (pop strobe, empty flag, registered data).
// Revision 1.0
`default_nettype none

interface sync_fifo_consumer_intf #(
  parameter int DATA_WIDTH = 16
);

  logic                  r_en;
  logic                  empty;
  logic [DATA_WIDTH-1:0] data_out;

  modport to_consumer (
    output r_en,
    input  empty,
    input  data_out
  );

  modport to_fifo (
    input  r_en,
    output empty,
    output data_out
  );

endinterface

`default_nettype wire

// File: rtl/fifo_consumer_addr_gen.sv
// fifo_consumer_addr_gen: down-stepping address counter with reload and past-end compare.
// Revision 1.0
`default_nettype none

module fifo_consumer_addr_gen #(
  parameter int ADDR_WIDTH = 20
) (
  input  wire logic                  clk,
  input  wire logic                  rstn,
  input  wire logic                  load,
  input  wire logic                  step,
  input  wire logic [ADDR_WIDTH-1:0] addr_begin,
  input  wire logic [ADDR_WIDTH-1:0] addr_nstep,
  input  wire logic [ADDR_WIDTH-1:0] addr_end,
  output logic      [ADDR_WIDTH-1:0] addr,
  output logic                       past_end
);

  // Subtraction wraps modulo 2^ADDR_WIDTH; an all-ones step therefore counts up by one.
  always_ff @(posedge clk) begin
    if (!rstn || load) begin
      addr <= addr_begin;
    end else if (step) begin
      addr <= addr - addr_nstep;
    end
  end

  assign past_end = (addr > addr_end);

endmodule

`default_nettype wire

// File: rtl/fifo_consumer.sv
// fifo_consumer: drains a sync FIFO into a RAM buffer in arbitrated bursts; option FIFO_CONSUMER_PERF_EN adds stall_cnt.
// Revision 1.0
`default_nettype none

module fifo_consumer
  import fifo_consumer_pkg::*;
  import single_port_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 20,
  parameter int BURST_SIZE = 4
) (
  input  wire logic                  clk,
  input  wire logic                  rstn,
  input  wire logic                  start,
  output logic                       request,
  input  wire logic                  grant,
  input  wire logic [ADDR_WIDTH-1:0] addr_begin,
  input  wire logic [ADDR_WIDTH-1:0] addr_nstep,
  input  wire logic [ADDR_WIDTH-1:0] addr_end,
  output logic                       done,
  sync_fifo_consumer_intf.to_consumer consumer,
  output logic                       to_buffer_cs,
  output logic                       to_buffer_oe,
  output logic      [ADDR_WIDTH-1:0] to_buffer_addr,
  input  wire logic [DATA_WIDTH-1:0] to_buffer_R_data,
  output logic                       to_buffer_W_req,
  output logic      [DATA_WIDTH-1:0] to_buffer_W_data
`ifdef FIFO_CONSUMER_PERF_EN
  ,
  output logic      [31:0]           stall_cnt
`endif
);

  localparam int               CNT_W     = $clog2(BURST_SIZE + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST_SIZE);

  fifo_consumer_state_t  state;
  logic [CNT_W-1:0]      burst_cnt;
  logic                  pend;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  rd_done;
  logic                  wr_past_end;
  logic                  active;
  logic                  in_burst;
  logic                  pop;
  logic                  wr_fire;
  logic                  unused_r_data;

  // start and reset suppress any handshake in the cycle they are seen
  assign active   = rstn && !start;
  assign in_burst = state[BURST_B];
  assign wr_fire  = active && pend && grant;
  assign pop      = active && in_burst && grant && !consumer.empty && !rd_done
                    && (!pend || wr_fire) && (burst_cnt < BURST_MAX);

  fifo_consumer_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_rd_addr (
    .clk        (clk),
    .rstn       (rstn),
    .load       (start),
    .step       (pop),
    .addr_begin (addr_begin),
    .addr_nstep (addr_nstep),
    .addr_end   (addr_end),
    .addr       (rd_addr),
    .past_end   (rd_done)
  );

  fifo_consumer_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_wr_addr (
    .clk        (clk),
    .rstn       (rstn),
    .load       (start),
    .step       (wr_fire),
    .addr_begin (addr_begin),
    .addr_nstep (addr_nstep),
    .addr_end   (addr_end),
    .addr       (wr_addr),
    .past_end   (wr_past_end)
  );

  always_ff @(posedge clk) begin
    if (!rstn || start) begin
      state     <= IDLE;
      burst_cnt <= '0;
      pend      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          burst_cnt <= '0;
          if (grant && !consumer.empty && !rd_done) begin
            state <= BURST;
          end
        end
        BURST: begin
          if (pop) begin
            burst_cnt <= burst_cnt + CNT_W'(1);
          end
          // leave only once the last popped word has been written back
          if (burst_cnt == BURST_MAX && !pend) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (pop) begin
        pend <= 1'b1;
      end else if (wr_fire) begin
        pend <= 1'b0;
      end
    end
  end

  assign consumer.r_en    = pop;
  assign done             = wr_past_end && !pend;
  assign request          = !done;
  assign to_buffer_cs     = wr_fire ? CS_EN : CS_DIS;
  assign to_buffer_oe     = OE_DIS;
  assign to_buffer_W_req  = wr_fire ? WREQ_EN : WREQ_DIS;
  assign to_buffer_addr   = wr_addr;
  assign to_buffer_W_data = wr_fire ? consumer.data_out : '0;

  assign unused_r_data = ^to_buffer_R_data;

`ifdef FIFO_CONSUMER_PERF_EN
  always_ff @(posedge clk) begin
    if (!rstn || start) begin
      stall_cnt <= '0;
    end else if (in_burst && consumer.empty && !rd_done && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_consumer.sv
// tb_fifo_consumer: directed self-checking bench for fifo_consumer (DW=16, AW=20, BURST_SIZE=4).
// Revision 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_fifo_consumer;
  import single_port_ram_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        start;
  logic        grant;
  logic        request;
  logic        done;
  logic [19:0] addr_begin;
  logic [19:0] addr_nstep;
  logic [19:0] addr_end;
  logic        to_buffer_cs;
  logic        to_buffer_oe;
  logic [19:0] to_buffer_addr;
  logic [15:0] to_buffer_R_data;
  logic        to_buffer_W_req;
  logic [15:0] to_buffer_W_data;
`ifdef FIFO_CONSUMER_PERF_EN
  logic [31:0] stall_cnt;
`endif

  sync_fifo_consumer_intf #(.DATA_WIDTH(16)) fif ();

  fifo_consumer #(
    .DATA_WIDTH (16),
    .ADDR_WIDTH (20),
    .BURST_SIZE (4)
  ) dut (
    .clk              (clk),
    .rstn             (rstn),
    .start            (start),
    .request          (request),
    .grant            (grant),
    .addr_begin       (addr_begin),
    .addr_nstep       (addr_nstep),
    .addr_end         (addr_end),
    .done             (done),
    .consumer         (fif.to_consumer),
    .to_buffer_cs     (to_buffer_cs),
    .to_buffer_oe     (to_buffer_oe),
    .to_buffer_addr   (to_buffer_addr),
    .to_buffer_R_data (to_buffer_R_data),
    .to_buffer_W_req  (to_buffer_W_req),
    .to_buffer_W_data (to_buffer_W_data)
`ifdef FIFO_CONSUMER_PERF_EN
    ,
    .stall_cnt        (stall_cnt)
`endif
  );

  // FIFO model: one-cycle read latency, data holds until the next pop
  logic [15:0] mem [0:63];
  int          wp = 0;
  int          rp = 0;
  logic        flush;

  assign fif.empty = (wp == rp);

  always @(posedge clk) begin
    if (flush) begin
      rp <= wp;
    end else if (fif.r_en && !fif.empty) begin
      fif.data_out <= mem[rp[5:0]];
      rp           <= rp + 1;
    end
  end

  // write/pop monitor
  logic        mon_clr;
  int          wcnt, ren_cnt, bad_ren, run, max_run;
  logic [19:0] waddr [0:31];
  logic [15:0] wdata [0:31];

  always @(negedge clk) begin
    if (mon_clr) begin
      wcnt    <= 0;
      ren_cnt <= 0;
      bad_ren <= 0;
      run     <= 0;
      max_run <= 0;
    end else begin
      if (to_buffer_W_req == WREQ_EN && to_buffer_cs == CS_EN) begin
        if (wcnt < 32) begin
          waddr[wcnt[4:0]] <= to_buffer_addr;
          wdata[wcnt[4:0]] <= to_buffer_W_data;
        end
        wcnt <= wcnt + 1;
      end
      if (fif.r_en) begin
        ren_cnt <= ren_cnt + 1;
        run     <= run + 1;
        if (run + 1 > max_run) max_run <= run + 1;
        if (fif.empty) bad_ren <= bad_ren + 1;
      end else begin
        run <= 0;
      end
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d);
    mem[wp[5:0]] = d;
    wp = wp + 1;
  endtask

  task automatic do_reset(input logic [19:0] b, input logic [19:0] n, input logic [19:0] e);
    rstn       = 1'b0;
    start      = 1'b0;
    grant      = 1'b0;
    addr_begin = b;
    addr_nstep = n;
    addr_end   = e;
    flush      = 1'b1;
    mon_clr    = 1'b1;
    step();
    step();
    flush   = 1'b0;
    mon_clr = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int k = 0;
    while (!done && k < max_cyc) begin
      step();
      k++;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  initial begin
    mon_clr          = 1'b1;
    flush            = 1'b1;
    rstn             = 1'b0;
    start            = 1'b0;
    grant            = 1'b0;
    addr_begin       = '0;
    addr_nstep       = '0;
    addr_end         = '0;
    to_buffer_R_data = 16'h5A5A;

    // 1: eight words, contiguous up-counting addresses, two bursts
    do_reset(20'h10, 20'hFFFFF, 20'h17);
    check("rst_r_en",    32'(fif.r_en),           32'd0);
    check("rst_cs",      32'(to_buffer_cs),       32'(CS_DIS));
    check("rst_oe",      32'(to_buffer_oe),       32'(OE_DIS));
    check("rst_wreq",    32'(to_buffer_W_req),    32'(WREQ_DIS));
    check("rst_wdata",   32'(to_buffer_W_data),   32'd0);
    check("rst_done",    32'(done),               32'd0);
    check("rst_request", 32'(request),            32'd1);
    for (int i = 0; i < 8; i++) push(16'hA000 + 16'(i));
    rstn  = 1'b1;
    grant = 1'b1;
    wait_done("t1_done", 60);
    check("t1_request", 32'(request), 32'd0);
    check("t1_wcnt",    32'(wcnt),    32'd8);
    check("t1_ren_cnt", 32'(ren_cnt), 32'd8);
    check("t1_max_run", 32'(max_run), 32'd4);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t1_addr%0d", i), 32'(waddr[i]), 32'h10 + 32'(i));
      check($sformatf("t1_data%0d", i), 32'(wdata[i]), 32'hA000 + 32'(i));
    end
    check("t1_oe", 32'(to_buffer_oe), 32'(OE_DIS));

    // 2: FIFO trickles one word every third cycle
    do_reset(20'h100, 20'hFFFFF, 20'h105);
    rstn  = 1'b1;
    grant = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push(16'hB000 + 16'(i));
      step();
      step();
      step();
    end
    wait_done("t2_done", 40);
    check("t2_bad_ren", 32'(bad_ren), 32'd0);
    check("t2_ren_cnt", 32'(ren_cnt), 32'd6);
    check("t2_wcnt",    32'(wcnt),    32'd6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t2_addr%0d", i), 32'(waddr[i]), 32'h100 + 32'(i));
      check($sformatf("t2_data%0d", i), 32'(wdata[i]), 32'hB000 + 32'(i));
    end

    // 3: grant withdrawn while a word is pending
    do_reset(20'h200, 20'hFFFFF, 20'h203);
    for (int i = 0; i < 4; i++) push(16'hC000 + 16'(i));
    rstn  = 1'b1;
    grant = 1'b1;
    step();
    check("t3_first_pop", 32'(fif.r_en), 32'd1);
    step();
    grant = 1'b0;
    #1;
    check("t3_hold_wreq0", 32'(to_buffer_W_req), 32'(WREQ_DIS));
    check("t3_hold_ren0",  32'(fif.r_en),        32'd0);
    step();
    check("t3_hold_wreq1", 32'(to_buffer_W_req), 32'(WREQ_DIS));
    check("t3_hold_ren1",  32'(fif.r_en),        32'd0);
    check("t3_hold_done",  32'(done),            32'd0);
    grant = 1'b1;
    #1;
    check("t3_resume_wreq", 32'(to_buffer_W_req),  32'(WREQ_EN));
    check("t3_resume_addr", 32'(to_buffer_addr),   32'h200);
    check("t3_resume_data", 32'(to_buffer_W_data), 32'hC000);
    wait_done("t3_done", 40);
    check("t3_wcnt", 32'(wcnt), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3_addr%0d", i), 32'(waddr[i]), 32'h200 + 32'(i));
      check($sformatf("t3_data%0d", i), 32'(wdata[i]), 32'hC000 + 32'(i));
    end

    // 4: begin beyond end, nothing to do
    do_reset(20'h20, 20'hFFFFF, 20'h1F);
    push(16'hE000);
    push(16'hE001);
    check("t4_rst_request", 32'(request), 32'd0);
    check("t4_rst_done",    32'(done),    32'd1);
    rstn  = 1'b1;
    grant = 1'b1;
    repeat (10) step();
    check("t4_request", 32'(request), 32'd0);
    check("t4_done",    32'(done),    32'd1);
    check("t4_ren_cnt", 32'(ren_cnt), 32'd0);
    check("t4_wcnt",    32'(wcnt),    32'd0);

    // 5: start mid-burst drops the in-flight word and reloads addresses
    do_reset(20'h300, 20'hFFFFF, 20'h30F);
    for (int i = 0; i < 8; i++) push(16'hD000 + 16'(i));
    rstn  = 1'b1;
    grant = 1'b1;
    step();
    step();
    step();
    start      = 1'b1;
    addr_begin = 20'h40;
    addr_end   = 20'h4F;
    #1;
    check("t5_start_wreq", 32'(to_buffer_W_req), 32'(WREQ_DIS));
    check("t5_start_ren",  32'(fif.r_en),        32'd0);
    step();
    start = 1'b0;
    step();
    step();
    check("t5_new_wreq", 32'(to_buffer_W_req),  32'(WREQ_EN));
    check("t5_new_addr", 32'(to_buffer_addr),   32'h40);
    check("t5_new_data", 32'(to_buffer_W_data), 32'hD002);
    step();
    grant = 1'b0;
    step();
    check("t5_wcnt",  32'(wcnt),     32'd2);
    check("t5_addr0", 32'(waddr[0]), 32'h300);
    check("t5_data0", 32'(wdata[0]), 32'hD000);
    check("t5_addr1", 32'(waddr[1]), 32'h40);
    check("t5_data1", 32'(wdata[1]), 32'hD002);

`ifdef FIFO_CONSUMER_PERF_EN
    // 6: stall counter over empty BURST cycles
    do_reset(20'h500, 20'hFFFFF, 20'h50F);
    push(16'hF000);
    rstn  = 1'b1;
    grant = 1'b1;
    check("t6_stall_rst", stall_cnt, 32'd0);
    step();
    step();
    repeat (5) step();
    check("t6_stall_5", stall_cnt, 32'd5);
    start = 1'b1;
    step();
    start = 1'b0;
    check("t6_stall_clr", stall_cnt, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
